// File: rtl/trace_vector_checker.sv
// Replays stimulus/expected-response records against an external DUT and
// tallies checked vectors, mismatches and the index of the first failure.
module trace_vector_checker #(
    parameter int IN_W   = 1,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             rec_valid,
    output logic             rec_ready,
    input  logic [IN_W-1:0]  rec_stim,
    input  logic [OUT_W-1:0] rec_exp,
    input  logic             rec_last,
    input  logic             clear,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             mismatch_pulse,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             done,
    output logic             pass
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A single settle cycle skips WAIT entirely so the compare lands one edge after the handshake.
    localparam logic [1:0] ST_AFTER_ACCEPT = (SETTLE == 1) ? ST_CHECK : ST_WAIT;
    localparam logic [7:0] SETTLE_LOAD     = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1'b1);
    endfunction

    logic [1:0]       r_state;
    logic [7:0]       r_settle;
    logic [OUT_W-1:0] r_exp;
    logic             r_last;
    logic [IN_W-1:0]  r_dut_in;
    logic             r_ready;
    logic             r_pulse;
    logic [CNT_W-1:0] r_vec;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] r_ffi;
    logic             r_done;
    logic             r_pass;

    logic             w_fire;
    logic             w_mis;
    logic [CNT_W-1:0] w_vec_nx;
    logic [CNT_W-1:0] w_err_nx;

    // Handshake qualification and next-count values for the compare cycle.
    always_comb begin
        w_fire   = 1'b0;
        w_mis    = 1'b0;
        w_vec_nx = sat_inc(r_vec);
        w_err_nx = r_err;
        if (rec_valid && r_ready && (r_state == ST_IDLE)) begin
            w_fire = 1'b1;
        end else begin
            w_fire = 1'b0;
        end
        if (dut_out != r_exp) begin
            w_mis    = 1'b1;
            w_err_nx = sat_inc(r_err);
        end else begin
            w_mis    = 1'b0;
            w_err_nx = r_err;
        end
    end

    // Main sequencer: accept, settle, compare, finish.
    always_ff @(posedge CK) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_settle <= 8'd0;
            r_exp    <= {OUT_W{1'b0}};
            r_last   <= 1'b0;
            r_dut_in <= {IN_W{1'b0}};
            r_ready  <= 1'b0;
            r_pulse  <= 1'b0;
            r_vec    <= CNT_ZERO;
            r_err    <= CNT_ZERO;
            r_ffi    <= CNT_ZERO;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_exp    <= rec_exp;
                        r_last   <= rec_last;
                        r_dut_in <= rec_stim;
                        r_settle <= SETTLE_LOAD;
                        r_ready  <= 1'b0;
                        r_state  <= ST_AFTER_ACCEPT;
                    end else begin
                        r_ready  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_settle <= 8'd1) begin
                        r_settle <= 8'd0;
                        r_state  <= ST_CHECK;
                    end else begin
                        r_settle <= r_settle - 8'd1;
                    end
                end
                ST_CHECK: begin
                    r_vec <= w_vec_nx;
                    r_err <= w_err_nx;
                    if (w_mis) begin
                        r_pulse <= 1'b1;
                        if (r_err == CNT_ZERO) begin
                            r_ffi <= r_vec;
                        end
                    end
                    if (r_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nx == CNT_ZERO);
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (clear) begin
                        r_state  <= ST_IDLE;
                        r_ready  <= 1'b1;
                        r_vec    <= CNT_ZERO;
                        r_err    <= CNT_ZERO;
                        r_ffi    <= CNT_ZERO;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_dut_in <= {IN_W{1'b0}};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign rec_ready      = r_ready;
    assign dut_in         = r_dut_in;
    assign mismatch_pulse = r_pulse;
    assign vec_count      = r_vec;
    assign err_count      = r_err;
    assign first_fail_idx = r_ffi;
    assign done           = r_done;
    assign pass           = r_pass;

endmodule

// File: tb/tb_trace_vector_checker.sv
// Directed bench: three checker instances drive an XOR-reduce DUT model with
// hand-built traces and compare status outputs against hand-computed values.
module tb_trace_vector_checker;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    logic       rst [3];
    logic       rv  [3];
    logic       re  [3];
    logic       rl  [3];
    logic       clr [3];
    logic [2:0] rs  [3];
    logic       rdy [3];
    logic       mp  [3];
    logic       dn  [3];
    logic       ps  [3];
    logic [2:0] din [3];
    logic       dout[3];
    logic [15:0] vc0, ec0, ff0, vc1, ec1, ff1;
    logic [1:0]  vc2, ec2, ff2;

    int errors = 0;
    int checks = 0;
    int pcnt[3] = '{0, 0, 0};
    int plast[3] = '{0, 0, 0};

    // DUT under replay: odd-parity of the stimulus.
    always_comb for (int i = 0; i < 3; i++) dout[i] = ^din[i];

    always @(negedge CK) begin
        for (int i = 0; i < 3; i++) begin
            if (mp[i] === 1'b1) begin
                pcnt[i]  <= pcnt[i] + 1;
                plast[i] <= cyc;
            end
        end
    end

    trace_vector_checker #(.IN_W(3), .OUT_W(1), .SETTLE(1), .CNT_W(16)) u0 (
        .CK(CK), .reset(rst[0]), .rec_valid(rv[0]), .rec_ready(rdy[0]), .rec_stim(rs[0]),
        .rec_exp(re[0]), .rec_last(rl[0]), .clear(clr[0]), .dut_in(din[0]), .dut_out(dout[0]),
        .mismatch_pulse(mp[0]), .vec_count(vc0), .err_count(ec0), .first_fail_idx(ff0),
        .done(dn[0]), .pass(ps[0]));

    trace_vector_checker #(.IN_W(3), .OUT_W(1), .SETTLE(4), .CNT_W(16)) u1 (
        .CK(CK), .reset(rst[1]), .rec_valid(rv[1]), .rec_ready(rdy[1]), .rec_stim(rs[1]),
        .rec_exp(re[1]), .rec_last(rl[1]), .clear(clr[1]), .dut_in(din[1]), .dut_out(dout[1]),
        .mismatch_pulse(mp[1]), .vec_count(vc1), .err_count(ec1), .first_fail_idx(ff1),
        .done(dn[1]), .pass(ps[1]));

    trace_vector_checker #(.IN_W(3), .OUT_W(1), .SETTLE(2), .CNT_W(2)) u2 (
        .CK(CK), .reset(rst[2]), .rec_valid(rv[2]), .rec_ready(rdy[2]), .rec_stim(rs[2]),
        .rec_exp(re[2]), .rec_last(rl[2]), .clear(clr[2]), .dut_in(din[2]), .dut_out(dout[2]),
        .mismatch_pulse(mp[2]), .vec_count(vc2), .err_count(ec2), .first_fail_idx(ff2),
        .done(dn[2]), .pass(ps[2]));

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic send(input int s, input logic [2:0] st, input logic ex, input logic la,
                        output int hs);
        int n;
        n = 0;
        rv[s] = 1'b1; rs[s] = st; re[s] = ex; rl[s] = la;
        while (rdy[s] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("handshake_timeout", 32'(rdy[s]), 32'd1);
        tick();
        hs = cyc;
        rv[s] = 1'b0; rs[s] = 3'd0; re[s] = 1'b0; rl[s] = 1'b0;
    endtask

    task automatic run_trace(input int s, input int nrec, input int bad, input bit all_bad,
                             output int gmin, output int gmax, output int hs_bad);
        int h, hp;
        logic [2:0] st;
        logic ex;
        gmin = 1000; gmax = 0; hp = 0; hs_bad = 0;
        for (int i = 0; i < nrec; i++) begin
            st = 3'(i);
            ex = ^st;
            if (all_bad || i == bad) ex = ~ex;
            send(s, st, ex, (i == nrec - 1), h);
            if (i == bad) hs_bad = h;
            if (i > 0) begin
                if (h - hp < gmin) gmin = h - hp;
                if (h - hp > gmax) gmax = h - hp;
            end
            hp = h;
        end
    endtask

    task automatic wait_done(input int s, input string tag);
        int n;
        n = 0;
        while (dn[s] !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(dn[s]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gmin, gmax, hsb, h;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0; rv[i] = 1'b0; re[i] = 1'b0; rl[i] = 1'b0; clr[i] = 1'b0; rs[i] = 3'd0;
        end
        tick(); tick();
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_dut_in", 32'(din[0]), 32'd0);
        chk("rst_vec", 32'(vc0), 32'd0);
        chk("rst_done", 32'(dn[0]), 32'd0);
        chk("rst_pass", 32'(ps[0]), 32'd0);
        chk("rst_pulse", 32'(mp[0]), 32'd0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        tick();
        chk("post_rst_ready", 32'(rdy[0]), 32'd1);

        // Clean 8-record trace, one record per two cycles.
        run_trace(0, 8, -1, 1'b0, gmin, gmax, hsb);
        chk("t1_done_not_yet", 32'(dn[0]), 32'd0);
        tick();
        chk("t1_done", 32'(dn[0]), 32'd1);
        chk("t1_pass", 32'(ps[0]), 32'd1);
        chk("t1_vec", 32'(vc0), 32'd8);
        chk("t1_err", 32'(ec0), 32'd0);
        chk("t1_dut_in_hold", 32'(din[0]), 32'd7);
        chk("t1_ready_done", 32'(rdy[0]), 32'd0);
        chk("t1_gap", 32'(gmin), 32'd2);
        chk("t1_pulses", 32'(pcnt[0]), 32'd0);

        // Clear from DONE, then clear in IDLE is a no-op.
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        chk("t6_ready", 32'(rdy[0]), 32'd1);
        chk("t6_vec", 32'(vc0), 32'd0);
        chk("t6_done", 32'(dn[0]), 32'd0);
        chk("t6_pass", 32'(ps[0]), 32'd0);
        chk("t6_dut_in", 32'(din[0]), 32'd0);
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        chk("t6_idle_clear_ready", 32'(rdy[0]), 32'd1);
        chk("t6_idle_clear_done", 32'(dn[0]), 32'd0);

        // Record 5 carries a wrong expectation.
        run_trace(0, 8, 5, 1'b0, gmin, gmax, hsb);
        wait_done(0, "t2_done");
        chk("t2_err", 32'(ec0), 32'd1);
        chk("t2_ffi", 32'(ff0), 32'd5);
        chk("t2_vec", 32'(vc0), 32'd8);
        chk("t2_pass", 32'(ps[0]), 32'd0);
        chk("t2_pulses", 32'(pcnt[0]), 32'd1);

        // clear and reset together: reset wins, so ready stays low.
        clr[0] = 1'b1; rst[0] = 1'b0; tick();
        chk("clr_rst_ready", 32'(rdy[0]), 32'd0);
        chk("clr_rst_err", 32'(ec0), 32'd0);
        clr[0] = 1'b0; rst[0] = 1'b1; tick();

        // SETTLE=4 back-to-back, record 1 wrong to time the compare edge.
        run_trace(1, 3, 1, 1'b0, gmin, gmax, hsb);
        wait_done(1, "t3_done");
        chk("t3_gap_min", 32'(gmin), 32'd5);
        chk("t3_gap_max", 32'(gmax), 32'd5);
        chk("t3_sample_edge", 32'(plast[1] - hsb), 32'd4);
        chk("t3_pulses", 32'(pcnt[1]), 32'd1);
        chk("t3_err", 32'(ec1), 32'd1);
        chk("t3_ffi", 32'(ff1), 32'd1);
        chk("t3_vec", 32'(vc1), 32'd3);

        // Reset while record 3 is settling, then replay the whole trace.
        rst[1] = 1'b0; tick(); rst[1] = 1'b1; tick();
        for (int i = 0; i < 3; i++) send(1, 3'(i), ^(3'(i)), 1'b0, h);
        send(1, 3'd3, 1'b0, 1'b0, h);
        chk("t4_vec_before", 32'(vc1), 32'd3);
        rst[1] = 1'b0; tick();
        chk("t4_ready", 32'(rdy[1]), 32'd0);
        chk("t4_dut_in", 32'(din[1]), 32'd0);
        chk("t4_vec", 32'(vc1), 32'd0);
        chk("t4_err", 32'(ec1), 32'd0);
        chk("t4_done", 32'(dn[1]), 32'd0);
        rst[1] = 1'b1;
        run_trace(1, 8, -1, 1'b0, gmin, gmax, hsb);
        wait_done(1, "t4_replay_done");
        chk("t4_replay_vec", 32'(vc1), 32'd8);
        chk("t4_replay_err", 32'(ec1), 32'd0);
        chk("t4_replay_pass", 32'(ps[1]), 32'd1);

        // Two-bit counters saturate under six failing records.
        run_trace(2, 6, -1, 1'b1, gmin, gmax, hsb);
        wait_done(2, "t5_done");
        chk("t5_vec", 32'(vc2), 32'd3);
        chk("t5_err", 32'(ec2), 32'd3);
        chk("t5_ffi", 32'(ff2), 32'd0);
        chk("t5_pass", 32'(ps[2]), 32'd0);
        chk("t5_gap", 32'(gmin), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
